hmmm_host_port: RTL and testbench
=================================

Name: hmmm_host_port

Overview:
- Host-side counterpart of the hmmm core's external pins.
- Loads a program into core RAM by sequencing pgrm_addr/pgrm_data cycles on the shared 16-bit bus, holds the core in reset while loading, then releases it.
- While the core runs, services its IO: drives the bus for core reads (in), captures the bus for core writes (out), and reports halt.
- Sits beside the core at chip top. Host side uses valid/ready streams.

Parameters:
- ADDR_W, 8, core RAM address width; load address counter width.
- DATA_W, 16, bus and word width.
- LOAD_BASE, 0, first RAM address written by a load.

Ports:
- clk  input  1  system clock; same clock as the core.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse in IDLE begins a load session.
- prog_valid  input  1  program word available.
- prog_ready  output  1  program word consumed this cycle.
- prog_word  input  DATA_W  program word.
- prog_last  input  1  marks the final word of the program.
- in_valid  input  1  host input word available for a core read.
- in_ready  output  1  input word consumed this cycle.
- in_data  input  DATA_W  host input word.
- out_valid  output  1  captured core output word pending.
- out_ready  input  1  host accepts out_data.
- out_data  output  DATA_W  last word written by the core.
- cpu_rst  output  1  drives core rst.
- pgrm_addr  output  1  drives core pgrm_addr.
- pgrm_data  output  1  drives core pgrm_data.
- bus  inout  DATA_W  shared core bus; driven only when bus_oe is high, else Z.
- cpu_read  input  1  core read strobe.
- cpu_write  input  1  core write strobe.
- cpu_halt  input  1  core halt.
- running  output  1  high in RUN.
- halted  output  1  high in HALTED.
- err  output  3  sticky flags: [0] load overflow, [1] input underflow, [2] output overrun.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cpu_rst=1, pgrm_addr=0, pgrm_data=0, bus released.
  - prog_ready=0, in_ready=0, out_valid=0, out_data=0, err=0.
  - Address counter set to LOAD_BASE.
- States: IDLE, LOAD_ADDR, LOAD_DATA, LOAD_WAIT, RUN, HALTED.
- cpu_rst is 1 in IDLE, LOAD_ADDR, LOAD_DATA and LOAD_WAIT, and 0 in RUN and HALTED. Core reset does not clear RAM.
- IDLE:
  - start=1 clears err and sets addr=LOAD_BASE.
  - Go to LOAD_ADDR if prog_valid=1, else LOAD_WAIT.
- LOAD_WAIT: go to LOAD_ADDR when prog_valid=1.
- LOAD_ADDR (1 cycle):
  - pgrm_addr=1; bus = zero-extended addr.
  - Always go to LOAD_DATA.
- LOAD_DATA (1 cycle):
  - pgrm_data=1; bus=prog_word; prog_ready=1, so the word is consumed at this edge.
  - The host holds prog_word stable from LOAD_ADDR through LOAD_DATA.
  - addr increments.
  - If prog_last=1: go to RUN (see Optional Feature).
  - Else if addr was all-ones: set err[0], go to RUN (wrap prohibited).
  - Else: LOAD_ADDR if prog_valid=1, else LOAD_WAIT.
- Steady-state load throughput: one word per 2 cycles.
- RUN, reads:
  - bus_oe = cpu_read (combinational); bus = in_valid ? in_data : 0.
  - Rising edge of cpu_read (cpu_read=1, registered copy=0) consumes the word: in_ready=1 that cycle when in_valid=1.
  - If in_valid=0 at that point: set err[1]; 0 is supplied.
  - A multi-cycle read holds the same word and consumes once.
- RUN, writes:
  - Rising edge of cpu_write captures bus into out_data and sets out_valid=1.
  - If out_valid is already 1 and out_ready=0: set err[2] and overwrite.
  - out_valid clears on out_valid & out_ready.
  - A capture and an accept in the same cycle leave out_valid=1 with the new data.
- HALTED:
  - Entered from RUN when cpu_halt=1.
  - The out stream keeps draining.
  - start=1 returns to IDLE→load, reasserting cpu_rst.
- Bus contention: the block never drives the bus in RUN unless cpu_read=1; it never drives in IDLE, LOAD_WAIT or HALTED.
- start outside IDLE/HALTED is ignored.
- An async reset mid-load aborts the load; RAM contents are then undefined.

Optional Feature:
- HOST_AUTOSTART_EN defined: a load with prog_last goes directly to RUN.
- Not defined: it goes to HALTED-equivalent state LOADED (cpu_rst=1) and needs a second start pulse to enter RUN.
- err[0] behaviour is identical in both cases.

Decomposition:
- Shared package hmmm_host_pkg holds:
  - state encoding localparams;
  - err bit indices ERR_LOAD_OVF=0, ERR_IN_UNDF=1, ERR_OUT_OVR=2;
  - DATA_W/ADDR_W defaults.
- One natural sub-module: hmmm_host_io, the RUN-time read/write servicer (edge detectors, out register, underflow/overrun flags).

Test Plan:
- Load 3 words 0x1001,0x2002,0x0000 (last) at LOAD_BASE=0 → pgrm_addr cycles with bus=0,1,2; pgrm_data cycles with the words; cpu_rst falls the cycle after the third LOAD_DATA (autostart); err=0.
- Gap in prog_valid between words → LOAD_WAIT, pgrm_* low, bus Z, cpu_rst stays 1.
- 256 words without prog_last → err[0]=1 after the word at addr 0xFF; RUN entered; no write to address 0.
- RUN, in_data=0x0042 valid, cpu_read high 3 cycles → bus=0x0042 all 3 cycles; in_ready exactly 1 pulse. Repeat with in_valid=0 → bus=0, err[1]=1.
- Two cpu_write strobes with bus=0x00AA then 0x00BB, out_ready=0 → out_data=0x00BB, err[2]=1; out_ready=1 then clears out_valid.
- Async rst asserted mid LOAD_DATA → all outputs at reset values immediately; bus Z; cpu_rst=1.

Source files
------------

// File: rtl/hmmm_host_pkg.sv
// Shared types and constants for the hmmm host port.
// State encoding, error bit indices and default widths.
package hmmm_host_pkg;

  localparam int HOST_DATA_W = 16;
  localparam int HOST_ADDR_W = 8;

  localparam int ERR_LOAD_OVF = 0;
  localparam int ERR_IN_UNDF  = 1;
  localparam int ERR_OUT_OVR  = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_ADDR = 3'd1;
  localparam logic [2:0] ST_LOAD_DATA = 3'd2;
  localparam logic [2:0] ST_LOAD_WAIT = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;
  localparam logic [2:0] ST_LOADED    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD_ADDR = ST_LOAD_ADDR,
    S_LOAD_DATA = ST_LOAD_DATA,
    S_LOAD_WAIT = ST_LOAD_WAIT,
    S_RUN       = ST_RUN,
    S_HALTED    = ST_HALTED,
    S_LOADED    = ST_LOADED
  } state_t;

endpackage

// File: rtl/hmmm_host_io.sv
// RUN-time servicer for core reads and writes:
// edge detectors, held read word, out register, io error flags.
module hmmm_host_io
  import hmmm_host_pkg::*;
#(
  parameter int DATA_W = HOST_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              clr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              undf,
  output logic              ovr
);

  logic              read_q;
  logic              write_q;
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] fresh;
  logic              rd_rise;
  logic              wr_rise;

  assign rd_rise  = run & cpu_read & ~read_q;
  assign wr_rise  = run & cpu_write & ~write_q;
  assign fresh    = in_valid ? in_data : '0;
  assign in_ready = rd_rise & in_valid;
  // later cycles of a long read keep showing the word taken at the edge
  assign rd_data  = rd_rise ? fresh : held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      held      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      undf      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      read_q  <= cpu_read;
      write_q <= cpu_write;
      if (rd_rise) held <= fresh;
      if (clr) undf <= 1'b0;
      else if (rd_rise & ~in_valid) undf <= 1'b1;
      if (wr_rise) begin
        out_data  <= bus_in;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      if (clr) ovr <= 1'b0;
      else if (wr_rise & out_valid & ~out_ready) ovr <= 1'b1;
    end
  end

endmodule

// File: rtl/hmmm_host_port.sv
// Host port for the hmmm core: program load sequencer plus RUN-time IO.
// Define HOST_AUTOSTART_EN to enter RUN straight after the last program word.
module hmmm_host_port
  import hmmm_host_pkg::*;
#(
  parameter int                ADDR_W    = HOST_ADDR_W,
  parameter int                DATA_W    = HOST_DATA_W,
  parameter logic [ADDR_W-1:0] LOAD_BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_word,
  input  logic              prog_last,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              cpu_rst,
  output logic              pgrm_addr,
  output logic              pgrm_data,
  inout  wire  [DATA_W-1:0] bus,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_halt,
  output logic              running,
  output logic              halted,
  output logic [2:0]        err
);

`ifdef HOST_AUTOSTART_EN
  localparam state_t S_DONE = S_RUN;
`else
  localparam state_t S_DONE = S_LOADED;
`endif

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic              ovf;
  logic              begin_load;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_drv;
  logic [DATA_W-1:0] rd_data;
  logic              undf;
  logic              ovr;

  assign begin_load = start & (state == S_IDLE || state == S_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_HALTED:
        if (start) nxt = prog_valid ? S_LOAD_ADDR : S_LOAD_WAIT;
        else if (state == S_IDLE) nxt = S_IDLE;
      S_LOAD_WAIT:
        if (prog_valid) nxt = S_LOAD_ADDR;
      S_LOAD_ADDR:
        nxt = S_LOAD_DATA;
      S_LOAD_DATA:
        if (prog_last)  nxt = S_DONE;
        else if (&addr) nxt = S_RUN;
        else            nxt = prog_valid ? S_LOAD_ADDR : S_LOAD_WAIT;
      S_RUN:
        if (cpu_halt) nxt = S_HALTED;
      S_LOADED:
        if (start) nxt = S_RUN;
      default:
        nxt = S_IDLE;
    endcase
  end

  // the address never wraps: a full RAM without prog_last ends the load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= LOAD_BASE;
      ovf  <= 1'b0;
    end else if (begin_load) begin
      addr <= LOAD_BASE;
      ovf  <= 1'b0;
    end else if (state == S_LOAD_DATA) begin
      addr <= addr + 1'b1;
      if (!prog_last && &addr) ovf <= 1'b1;
    end
  end

  always_comb begin
    bus_oe  = 1'b0;
    bus_drv = '0;
    case (state)
      S_LOAD_ADDR: begin
        bus_oe  = 1'b1;
        bus_drv = DATA_W'(addr);
      end
      S_LOAD_DATA: begin
        bus_oe  = 1'b1;
        bus_drv = prog_word;
      end
      S_RUN: begin
        bus_oe  = cpu_read;
        bus_drv = rd_data;
      end
      default: ;
    endcase
  end

  assign bus = bus_oe ? bus_drv : 'z;

  assign pgrm_addr  = (state == S_LOAD_ADDR);
  assign pgrm_data  = (state == S_LOAD_DATA);
  assign prog_ready = (state == S_LOAD_DATA);
  assign running    = (state == S_RUN);
  assign halted     = (state == S_HALTED);
  assign cpu_rst    = ~(running | halted);

  always_comb begin
    err               = '0;
    err[ERR_LOAD_OVF] = ovf;
    err[ERR_IN_UNDF]  = undf;
    err[ERR_OUT_OVR]  = ovr;
  end

  hmmm_host_io #(.DATA_W(DATA_W)) u_io (
    .clk       (clk),
    .rst       (rst),
    .run       (running),
    .clr       (begin_load),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .bus_in    (bus),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rd_data   (rd_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .undf      (undf),
    .ovr       (ovr)
  );

endmodule

// File: tb/tb_hmmm_host_port.sv
// Directed bench for hmmm_host_port: load, gap, overflow, IO, reset.
// Works with or without HOST_AUTOSTART_EN.
module tb_hmmm_host_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        prog_valid = 1'b0;
  logic        prog_ready;
  logic [15:0] prog_word = '0;
  logic        prog_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        cpu_rst;
  logic        pgrm_addr;
  logic        pgrm_data;
  wire  [15:0] bus;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic        cpu_halt = 1'b0;
  logic        running;
  logic        halted;
  logic [2:0]  err;

  logic        core_oe = 1'b0;
  logic [15:0] core_drv = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign bus = core_oe ? core_drv : 'z;

  always #5 clk = ~clk;

  hmmm_host_port dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_valid (prog_valid),
    .prog_ready (prog_ready),
    .prog_word  (prog_word),
    .prog_last  (prog_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cpu_rst    (cpu_rst),
    .pgrm_addr  (pgrm_addr),
    .pgrm_data  (pgrm_data),
    .bus        (bus),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_halt   (cpu_halt),
    .running    (running),
    .halted     (halted),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // drive two opposite patterns; any DUT drive would corrupt one of them
  task automatic chk_released(input string tag);
    core_oe  = 1'b1;
    core_drv = 16'h5A5A;
    #1 check(tag, bus, 16'h5A5A);
    core_drv = 16'hA5A5;
    #1 check(tag, bus, 16'hA5A5);
    core_oe  = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w, input logic last,
                           input logic [15:0] a, input logic gap);
    prog_valid = 1'b1;
    prog_word  = w;
    prog_last  = last;
    #1;
    check("ld_addr_strobe", pgrm_addr, 1);
    check("ld_addr_bus", bus, a);
    check("ld_addr_rst", cpu_rst, 1);
    cyc();
    if (gap) prog_valid = 1'b0;
    #1;
    check("ld_data_strobe", pgrm_data, 1);
    check("ld_data_bus", bus, w);
    check("ld_data_ready", prog_ready, 1);
    cyc();
    prog_last = 1'b0;
    if (gap) begin
      repeat (2) begin
        #1;
        check("wait_pa", pgrm_addr, 0);
        check("wait_pd", pgrm_data, 0);
        check("wait_rst", cpu_rst, 1);
        check("wait_ready", prog_ready, 0);
        chk_released("wait_bus");
        cyc();
      end
      prog_valid = 1'b1;
      cyc();
    end
  endtask

  initial begin
    #3;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_pa", pgrm_addr, 0);
    check("rst_pd", pgrm_data, 0);
    check("rst_pready", prog_ready, 0);
    check("rst_iready", in_ready, 0);
    check("rst_ovalid", out_valid, 0);
    check("rst_odata", out_data, 0);
    check("rst_err", err, 0);
    check("rst_running", running, 0);
    chk_released("rst_bus");
    cyc();
    rst = 1'b0;
    cyc();

    // three-word load with a gap after the first word
    prog_valid = 1'b1;
    prog_word  = 16'h1001;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    load_word(16'h1001, 1'b0, 16'd0, 1'b1);
    load_word(16'h2002, 1'b0, 16'd1, 1'b0);
    load_word(16'h0000, 1'b1, 16'd2, 1'b0);
    prog_valid = 1'b0;
    #1;
`ifdef HOST_AUTOSTART_EN
    check("auto_running", running, 1);
    check("auto_cpu_rst", cpu_rst, 0);
`else
    check("loaded_running", running, 0);
    check("loaded_cpu_rst", cpu_rst, 1);
    chk_released("loaded_bus");
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
    check("run_running", running, 1);
    check("run_cpu_rst", cpu_rst, 0);
`endif
    check("load_err", err, 0);
    chk_released("run_idle_bus");

    // multi-cycle read with a valid word
    in_data  = 16'h0042;
    in_valid = 1'b1;
    cpu_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rd_bus", bus, 16'h0042);
      check("rd_ready", in_ready, (i == 0));
      cyc();
    end
    cpu_read = 1'b0;
    #1 check("rd_end_ready", in_ready, 0);
    cyc();

    // read with no word available
    in_valid = 1'b0;
    in_data  = 16'h0077;
    cpu_read = 1'b1;
    #1;
    check("undf_bus", bus, 0);
    check("undf_ready", in_ready, 0);
    cyc();
    #1;
    check("undf_bus2", bus, 0);
    check("undf_err", err, 3'b010);
    cpu_read = 1'b0;
    cyc();

    // two writes with the host stalled
    core_oe   = 1'b1;
    core_drv  = 16'h00AA;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
    #1;
    check("wr1_valid", out_valid, 1);
    check("wr1_data", out_data, 16'h00AA);
    check("wr1_err", err, 3'b010);
    cyc();
    core_drv  = 16'h00BB;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
    core_oe   = 1'b0;
    #1;
    check("wr2_data", out_data, 16'h00BB);
    check("wr2_err", err, 3'b110);
    check("wr2_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #1 check("drain_valid", out_valid, 0);

    // capture and accept in the same cycle
    core_oe   = 1'b1;
    core_drv  = 16'h00CC;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
    #1 check("wr3_data", out_data, 16'h00CC);
    cyc();
    core_drv  = 16'h00DD;
    cpu_write = 1'b1;
    out_ready = 1'b1;
    cyc();
    cpu_write = 1'b0;
    out_ready = 1'b0;
    core_oe   = 1'b0;
    #1;
    check("both_valid", out_valid, 1);
    check("both_data", out_data, 16'h00DD);
    check("both_err", err, 3'b110);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #1 check("both_drain", out_valid, 0);

    // halt
    cpu_halt = 1'b1;
    cyc();
    cpu_halt = 1'b0;
    #1;
    check("halt_halted", halted, 1);
    check("halt_running", running, 0);
    check("halt_cpu_rst", cpu_rst, 0);
    cpu_read = 1'b1;
    chk_released("halt_bus");
    check("halt_iready", in_ready, 0);
    cpu_read = 1'b0;

    // 256 words without prog_last overflow the RAM
    prog_valid = 1'b1;
    prog_word  = 16'hC300;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    #1 check("reload_err_clr", err, 0);
    for (int i = 0; i < 256; i++)
      load_word(16'hC300 ^ 16'(i), 1'b0, 16'(i), 1'b0);
    prog_valid = 1'b0;
    #1;
    check("ovf_running", running, 1);
    check("ovf_cpu_rst", cpu_rst, 0);
    check("ovf_err", err, 3'b001);
    check("ovf_pa", pgrm_addr, 0);
    cyc();
    #1 check("ovf_pa2", pgrm_addr, 0);

    // leave a pending out word, then reset in the middle of a load
    core_oe   = 1'b1;
    core_drv  = 16'h00EE;
    cpu_write = 1'b1;
    cyc();
    cpu_write = 1'b0;
    core_oe   = 1'b0;
    #1 check("pend_valid", out_valid, 1);
    cpu_halt = 1'b1;
    cyc();
    cpu_halt   = 1'b0;
    prog_valid = 1'b1;
    prog_word  = 16'h1234;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    #1 check("rl_pa", pgrm_addr, 1);
    cyc();
    #1 check("rl_pd", pgrm_data, 1);
    rst = 1'b1;
    #1;
    check("arst_pd", pgrm_data, 0);
    check("arst_pa", pgrm_addr, 0);
    check("arst_cpu_rst", cpu_rst, 1);
    check("arst_pready", prog_ready, 0);
    check("arst_ovalid", out_valid, 0);
    check("arst_odata", out_data, 0);
    check("arst_err", err, 0);
    chk_released("arst_bus");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
